muldiv_hilo_unit: RTL and testbench

HI/LO multiply/divide unit that executes the mult/multu/div/divu, mfhi/mflo and mthi/mtlo operations decoded by the pipeline controller. It is accepted from the execute stage, runs iterative arithmetic, and holds the architectural HI and LO registers. It raises `busy` so the hazard unit stalls any later HI/LO access until the result is written. The mfhi/mflo read data returns through the M/W path selected by the controller's move-from-MU signal.

---
 rtl/muldiv_hilo_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// Iterative HI/LO multiply/divide unit with mthi/mtlo moves and mfhi/mflo read mux.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divides stay iterative.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startE,
   input  logic [1:0]       opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             wrhiE,
   input  logic             wrloE,
   input  logic             cancel,
   input  logic             rdhi,
   output logic [WIDTH-1:0] hilo_rdata,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_CALC = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_hi, r_lo;
   logic [WIDTH-1:0]     r_a, r_b, r_dvd;
   logic [1:0]           r_op;
   logic                 r_sign_a, r_sign_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [5:0]           r_cnt;
   logic                 r_busy, r_done;

   logic                 w_idle, w_accept, w_fast, w_launch, w_fix_write, w_signed;
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_rem_shift;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_diff;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_prod_fix;
   logic [WIDTH-1:0]     w_quot_fix, w_rem_fix, w_a_abs, w_b_abs;
   logic [WIDTH-1:0]     w_fix_hi, w_fix_lo;

   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
      f_abs = v[WIDTH-1] ? (~v + ONE_W) : v;
   endfunction

   assign w_idle      = (r_state == S_IDLE);
   assign w_accept    = w_idle & startE;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fa, w_fb, w_fast_prod;
   assign w_fast      = w_accept & ~opE[1];
   // Sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both mult and multu.
   assign w_fa        = opE[0] ? {{WIDTH{1'b0}}, srcaE} : {{WIDTH{srcaE[WIDTH-1]}}, srcaE};
   assign w_fb        = opE[0] ? {{WIDTH{1'b0}}, srcbE} : {{WIDTH{srcbE[WIDTH-1]}}, srcbE};
   assign w_fast_prod = w_fa * w_fb;
`else
   assign w_fast      = 1'b0;
`endif
   assign w_launch    = w_accept & ~w_fast;
   assign w_fix_write = (r_state == S_FIX) & ~cancel;
   assign w_signed    = ~r_op[0];

   assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
   assign w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Restoring divide: acc holds {remainder, dividend/quotient}; one quotient bit per cycle.
   assign w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge        = (w_rem_shift >= {1'b0, r_b});
   assign w_diff      = w_rem_shift[WIDTH-1:0] - r_b;
   assign w_div_next  = {(w_ge ? w_diff : w_rem_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

   assign w_a_abs     = w_signed ? f_abs(r_a) : r_a;
   assign w_b_abs     = w_signed ? f_abs(r_b) : r_b;
   assign w_prod_fix  = (r_sign_a ^ r_sign_b) ? (~r_acc + ONE_2W) : r_acc;
   assign w_quot_fix  = (r_sign_a ^ r_sign_b) ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0];
   assign w_rem_fix   = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + ONE_W) : r_acc[2*WIDTH-1:WIDTH];

   // Final HI/LO selection, including the divide-by-zero convention.
   always_comb begin
      w_fix_hi = r_hi;
      w_fix_lo = r_lo;
      if (!r_op[1]) begin
         w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod_fix[WIDTH-1:0];
      end else if (r_b == {WIDTH{1'b0}}) begin
         w_fix_hi = r_dvd;
         w_fix_lo = {WIDTH{1'b1}};
      end else begin
         w_fix_hi = w_rem_fix;
         w_fix_lo = w_quot_fix;
      end
   end

   // Next-state logic; cancel aborts any active operation.
   always_comb begin
      w_next = r_state;
      if (cancel && !w_idle) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_next = w_launch ? S_PREP : S_IDLE;
            S_PREP:  w_next = S_CALC;
            S_CALC:  w_next = (r_cnt == 6'd0) ? S_FIX : S_CALC;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Datapath, HI/LO and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi     <= {WIDTH{1'b0}};
         r_lo     <= {WIDTH{1'b0}};
         r_a      <= {WIDTH{1'b0}};
         r_b      <= {WIDTH{1'b0}};
         r_dvd    <= {WIDTH{1'b0}};
         r_op     <= 2'd0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_acc    <= {(2*WIDTH){1'b0}};
         r_cnt    <= 6'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= w_fix_write;
         case (r_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_a   <= srcaE;
                  r_b   <= srcbE;
                  r_dvd <= srcaE;
                  r_op  <= opE;
`ifdef MULDIV_FAST_MUL_EN
               end else if (w_fast) begin
                  r_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_fast_prod[WIDTH-1:0];
`endif
               end else begin
                  if (wrhiE) r_hi <= srcaE;
                  if (wrloE) r_lo <= srcaE;
               end
            end
            S_PREP: begin
               r_sign_a <= w_signed & r_a[WIDTH-1];
               r_sign_b <= w_signed & r_b[WIDTH-1];
               r_a      <= w_a_abs;
               r_b      <= w_b_abs;
               r_acc    <= {{WIDTH{1'b0}}, (r_op[1] ? w_a_abs : w_b_abs)};
               r_cnt    <= 6'd31;
            end
            S_CALC: begin
               r_acc <= r_op[1] ? w_div_next : w_mul_next;
               r_cnt <= r_cnt - 6'd1;
            end
            S_FIX: begin
               if (w_fix_write) begin
                  r_hi <= w_fix_hi;
                  r_lo <= w_fix_lo;
               end
            end
            default: begin
               r_cnt <= 6'd0;
            end
         endcase
      end
   end

   assign hilo_rdata = rdhi ? r_hi : r_lo;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit: latency, results, moves, cancel, async reset.
module tb_muldiv_hilo_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        startE;
   logic [1:0]  opE;
   logic [31:0] srcaE, srcbE;
   logic        wrhiE, wrloE, cancel, rdhi;
   logic [31:0] hilo_rdata;
   logic        busy, done;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_hilo_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .startE(startE), .opE(opE),
      .srcaE(srcaE), .srcbE(srcbE), .wrhiE(wrhiE), .wrloE(wrloE),
      .cancel(cancel), .rdhi(rdhi), .hilo_rdata(hilo_rdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      rdhi = 1'b1;
      #1;
      hi = hilo_rdata;
      rdhi = 1'b0;
      #1;
      lo = hilo_rdata;
   endtask

   // Called in cycle 1 after issue; counts busy cycles, then checks the done pulse.
   task automatic wait_result(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         step(1);
      end
      check_eq({tag, "_latency"}, n, 32'd34);
      check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
      step(1);
      check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic wr,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] hi, lo;
      startE = 1'b1; opE = op; srcaE = a; srcbE = b; wrhiE = wr; wrloE = wr;
      step(1);
      startE = 1'b0; wrhiE = 1'b0; wrloE = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) begin
         check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
         check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
      end else begin
         wait_result(tag);
      end
`else
      wait_result(tag);
`endif
      read_hilo(hi, lo);
      check_eq({tag, "_hi"}, hi, exp_hi);
      check_eq({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] hi, lo;
      int          n_done;
      reset = 1'b0; startE = 1'b0; opE = 2'd0; srcaE = 32'd0; srcbE = 32'd0;
      wrhiE = 1'b0; wrloE = 1'b0; cancel = 1'b0; rdhi = 1'b0;
      #2;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      read_hilo(hi, lo);
      check_eq("rst_hi", hi, 32'd0);
      check_eq("rst_lo", lo, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(1);

      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg",  2'b00, 32'hFFFFFFF9, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("div_neg",   2'b10, 32'hFFFFFFEF, 32'd5,        1'b0, 32'hFFFFFFFE, 32'hFFFFFFFD);
      run_op("divu_zero", 2'b11, 32'h00001234, 32'd0,        1'b0, 32'h00001234, 32'hFFFFFFFF);
      run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);

      srcaE = 32'h11112222; wrhiE = 1'b1;
      step(1);
      wrhiE = 1'b0;
      read_hilo(hi, lo);
      check_eq("mthi_hi", hi, 32'h11112222);
      check_eq("mthi_lo_kept", lo, 32'h80000000);
      srcaE = 32'h33334444; wrloE = 1'b1;
      step(1);
      wrloE = 1'b0;
      read_hilo(hi, lo);
      check_eq("mtlo_lo", lo, 32'h33334444);

      // startE with mthi/mtlo: writes dropped, divide result lands.
      run_op("start_wins", 2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);

      startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd3;
      step(1);
      startE = 1'b0;
      step(4);
      check_eq("c5_busy", {31'd0, busy}, 32'd1);
      srcaE = 32'hAAAA5555; wrhiE = 1'b1;
      step(1);
      wrhiE = 1'b0;
      read_hilo(hi, lo);
      check_eq("busy_mthi_ignored", hi, 32'd2);
      check_eq("busy_lo_preop", lo, 32'd14);
      step(4);
      cancel = 1'b1;
      step(1);
      cancel = 1'b0;
      check_eq("cancel_busy", {31'd0, busy}, 32'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) n_done++;
         step(1);
      end
      check_eq("cancel_no_done", n_done, 32'd0);
      read_hilo(hi, lo);
      check_eq("cancel_hi", hi, 32'd2);
      check_eq("cancel_lo", lo, 32'd14);

      startE = 1'b1; opE = 2'b11; srcaE = 32'd5; srcbE = 32'd6;
      step(1);
      startE = 1'b0;
      step(19);
      check_eq("c20_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check_eq("arst_busy", {31'd0, busy}, 32'd0);
      check_eq("arst_done", {31'd0, done}, 32'd0);
      read_hilo(hi, lo);
      check_eq("arst_hi", hi, 32'd0);
      check_eq("arst_lo", lo, 32'd0);
      step(1);
      reset = 1'b1;
      step(1);
      run_op("post_reset", 2'b11, 32'd50, 32'd7, 1'b0, 32'd1, 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
